// File: rtl/mfp_ahb_uart_tx_pkg.sv
// Purpose: shared constants, register map and FSM encoding for the AHB UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mfp_ahb_uart_tx_pkg;

    // Byte offsets of the software-visible registers
    localparam logic [3:0] MFP_UART_TX_DATA_OFS = 4'h0;
    localparam logic [3:0] MFP_UART_TX_STAT_OFS = 4'h4;

    // Register index as decoded from HADDR[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // STATUS bit positions
    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    // Index of the last data bit in an 8N1 frame
    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // The STATUS count field is 4 bits wide; a completely full 16-deep FIFO reads as 15
    function automatic logic [3:0] sat_count4(input int unsigned cnt);
        return (cnt > 32'd15) ? 4'hF : cnt[3:0];
    endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// Purpose: synchronous first-word fall-through FIFO holding bytes queued for transmission.
// Latency: a push is visible at dout/empty one cycle later; pop takes effect on the same edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module mfp_sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    logic [WIDTH-1:0]   mem_q [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               do_pop;
    logic               do_push;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts it
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mfp_ahb_uart_tx.sv
// Purpose: AHB-Lite slave with TX FIFO and 8N1 UART serialiser plus a polled STATUS register.
// Latency: write data phase in cycle N -> FIFO non-empty N+1 -> UART_TX start bit at N+2.
// Backpressure: none on the bus (zero wait states); bytes written to a full FIFO are dropped and flag overflow.
module mfp_ahb_uart_tx
    import mfp_ahb_uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        UART_TX,
    output logic        TX_IRQ
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    // Address-phase capture
    logic       sel_q;
    logic       wr_q;
    logic [1:0] a_q;

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    // Data-phase decode and status
    logic        wr_txdata;
    logic        wr_status;
    logic        ovf_q;
    logic        ovf_d;
    logic [31:0] status;

    // Serialiser state
    tx_state_e  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        baud_done;

    // Bus bits the register map does not decode
    logic unused_bus_bits;
    assign unused_bus_bits = ^{HADDR[1:0], HTRANS[0], HWDATA[31:8]};

    // Register the address phase; only NONSEQ/SEQ transfers to this slave count
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= 1'b0;
            wr_q  <= 1'b0;
            a_q   <= 2'd0;
        end else begin
            sel_q <= HSEL && HTRANS[1];
            wr_q  <= HWRITE;
            a_q   <= HADDR[3:2];
        end
    end

    assign wr_txdata = sel_q && wr_q && (a_q == REG_TXDATA);
    assign wr_status = sel_q && wr_q && (a_q == REG_STATUS);
    assign fifo_push = wr_txdata;

    mfp_sync_fifo #(
        .WIDTH   (8),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (HWDATA[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow: set on a dropped byte, cleared by writing 1 to its STATUS bit
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && HWDATA[ST_OVF_BIT]) ovf_d = 1'b0;
        if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
    end

    // Overflow flag register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    // Assemble the STATUS word from live FIFO/FSM state
    always_comb begin
        status                          = 32'h0;
        status[ST_FULL_BIT]             = fifo_full;
        status[ST_EMPTY_BIT]            = fifo_empty;
        status[ST_BUSY_BIT]             = (state_q != TX_IDLE);
        status[ST_OVF_BIT]              = ovf_q;
        status[ST_CNT_LSB +: 4]         = sat_count4(int'(fifo_count));
    end

    // Read-data mux; everything except STATUS, and any unselected cycle, reads zero
    always_comb begin
        HRDATA = 32'h0;
        if (sel_q && (a_q == REG_STATUS)) HRDATA = status;
    end

    assign baud_done = (baud_q == 16'd0);

    // Serialiser next-state: each state holds for one baud period, STOP chains straight into START
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    baud_d   = BAUD_RELOAD;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == LAST_DATA_BIT) state_d = TX_STOP;
                    else                        bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        baud_d   = BAUD_RELOAD;
                        state_d  = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        // Line level is registered alongside the state so UART_TX comes straight from a flop
        unique case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Serialiser state registers; reset abandons any frame and returns the line high
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= TX_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign UART_TX = tx_q;
    assign TX_IRQ  = fifo_empty && (state_q == TX_IDLE);

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Purpose: scoreboard bench for mfp_ahb_uart_tx with BAUD_DIV=4, FIFO_AW=2.
// Latency: frames decoded by a line monitor; reads checked in their data phase.
// Backpressure: none exercised beyond FIFO overflow.
module tb_mfp_ahb_uart_tx;

    localparam int BD = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [3:0]  HADDR = 4'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = 32'h0;
    logic [31:0] HRDATA;
    logic        UART_TX;
    logic        TX_IRQ;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] rd_exp[$];
    int          starts[$];
    logic [7:0]  wbuf [0:7];
    int          last_dp;

    logic        tb_rd_req = 1'b0;
    logic        rd_dp;

    // Line monitor state
    logic        mon_busy = 1'b0;
    logic        mon_prev = 1'b1;
    int          mon_start = 0;
    logic [7:0]  mon_byte = 8'h0;

    mfp_ahb_uart_tx #(.BAUD_DIV(BD), .FIFO_AW(2)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .HSEL    (HSEL),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .UART_TX (UART_TX),
        .TX_IRQ  (TX_IRQ)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Track which cycles are data phases of bench-issued reads
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rd_dp <= 1'b0;
        else          rd_dp <= tb_rd_req;
    end

    // Read-data monitor
    always @(negedge HCLK) begin
        if (HRESETn && rd_dp) begin
            if (rd_exp.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else                    chk("hrdata", HRDATA, rd_exp.pop_front());
        end
    end

    // UART line monitor: samples mid-bit, compares each frame against the expected-byte queue
    always @(negedge HCLK) begin
        int off;
        if (!HRESETn) begin
            mon_busy = 1'b0;
            mon_prev = 1'b1;
        end else begin
            if (!mon_busy) begin
                if (mon_prev && !UART_TX) begin
                    mon_busy  = 1'b1;
                    mon_start = cyc;
                    mon_byte  = 8'h0;
                    starts.push_back(cyc);
                end
            end else begin
                off = cyc - mon_start;
                if (off == BD/2) chk("start_bit", {31'h0, UART_TX}, 32'd0);
                if (off >= BD + BD/2 && off <= 8*BD + BD/2 && (off % BD) == BD/2)
                    mon_byte = {UART_TX, mon_byte[7:1]};
                if (off == 9*BD + BD/2) begin
                    chk("stop_bit", {31'h0, UART_TX}, 32'd1);
                    if (exp_q.size() == 0) chk("frame_unexpected", {24'h0, mon_byte}, 32'hFFFFFFFF);
                    else                   chk("frame_byte", {24'h0, mon_byte}, {24'h0, exp_q.pop_front()});
                    mon_busy = 1'b0;
                end
            end
            mon_prev = UART_TX;
        end
    end

    // Pipelined write burst of n bytes from wbuf; last_dp is the last data-phase cycle
    task automatic wr_burst(input logic [3:0] addr, input int n, input logic sel, input logic [1:0] trans);
        for (int i = 0; i <= n; i++) begin
            @(negedge HCLK);
            if (i > 0) HWDATA = {24'h0, wbuf[i-1]};
            if (i < n) begin
                HSEL = sel; HADDR = addr; HTRANS = trans; HWRITE = 1'b1;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
            end
        end
        last_dp = cyc;
    endtask

    task automatic rd(input logic [3:0] addr, input logic sel, input logic [1:0] trans, input logic [31:0] exp);
        @(negedge HCLK);
        HSEL = sel; HADDR = addr; HTRANS = trans; HWRITE = 1'b0; tb_rd_req = 1'b1;
        rd_exp.push_back(exp);
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; tb_rd_req = 1'b0;
    endtask

    // Wait until n frames have started and the transmitter is idle again
    task automatic wait_done(input string name, input int n_starts, input int budget);
        int k;
        k = 0;
        while (!(starts.size() >= n_starts && TX_IRQ && !mon_busy) && k < budget) begin
            @(negedge HCLK);
            k++;
        end
        chk(name, {31'h0, (k < budget)}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int s0;

        // Reset state
        repeat (3) @(negedge HCLK);
        chk("rst_tx", {31'h0, UART_TX}, 32'd1);
        chk("rst_irq", {31'h0, TX_IRQ}, 32'd1);
        chk("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        rd(4'h4, 1'b1, 2'b10, 32'h0000_0002);

        // Single byte 0xA5: latency, busy status, IRQ timing
        wbuf[0] = 8'hA5;
        exp_q.push_back(8'hA5);
        s0 = starts.size();
        wr_burst(4'h0, 1, 1'b1, 2'b10);
        n = last_dp;
        repeat (8) @(negedge HCLK);
        rd(4'h4, 1'b1, 2'b10, 32'h0000_0006);
        while (cyc < n + 41) @(negedge HCLK);
        chk("irq_n41", {31'h0, TX_IRQ}, 32'd0);
        @(negedge HCLK);
        chk("irq_n42", {31'h0, TX_IRQ}, 32'd1);
        chk("a5_started", starts.size(), s0 + 1);
        if (starts.size() > s0) chk("start_latency", starts[s0] - n, 32'd2);

        // Three back-to-back bytes: frames must abut exactly
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        s0 = starts.size();
        wr_burst(4'h0, 3, 1'b1, 2'b10);
        wait_done("b2b_done", s0 + 3, 400);
        chk("b2b_frames", starts.size(), s0 + 3);
        if (starts.size() >= s0 + 3) begin
            chk("b2b_gap1", starts[s0+1] - starts[s0], 32'd40);
            chk("b2b_gap2", starts[s0+2] - starts[s0+1], 32'd40);
        end

        // Overflow: 6 writes, 5 accepted, sixth dropped
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        wbuf[3] = 8'h44; wbuf[4] = 8'h55; wbuf[5] = 8'h66;
        for (int i = 0; i < 5; i++) exp_q.push_back(wbuf[i]);
        s0 = starts.size();
        wr_burst(4'h0, 6, 1'b1, 2'b10);
        rd(4'h4, 1'b1, 2'b10, 32'h0000_004D);
        wbuf[0] = 8'h08;
        wr_burst(4'h4, 1, 1'b1, 2'b10);
        rd(4'h4, 1'b1, 2'b10, 32'h0000_0045);
        wait_done("ovf_drain", s0 + 5, 600);
        chk("ovf_frames", starts.size(), s0 + 5);
        rd(4'h4, 1'b1, 2'b10, 32'h0000_0002);

        // Reset in the middle of data bit 3 of a 0x00 frame
        wbuf[0] = 8'h00;
        exp_q.push_back(8'h00);
        wr_burst(4'h0, 1, 1'b1, 2'b10);
        n = last_dp;
        while (cyc < n + 19) @(negedge HCLK);
        chk("pre_rst_tx", {31'h0, UART_TX}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("async_rst_tx", {31'h0, UART_TX}, 32'd1);
        chk("async_rst_irq", {31'h0, TX_IRQ}, 32'd1);
        chk("async_rst_hrdata", HRDATA, 32'h0);
        repeat (3) @(negedge HCLK);
        exp_q.delete();
        HRESETn = 1'b1;
        s0 = starts.size();
        repeat (60) @(negedge HCLK);
        chk("no_residual_frame", starts.size(), s0);
        chk("post_rst_tx", {31'h0, UART_TX}, 32'd1);
        rd(4'h4, 1'b1, 2'b10, 32'h0000_0002);

        // Reads of non-status registers and non-selected/idle accesses
        rd(4'h0, 1'b1, 2'b10, 32'h0);
        rd(4'hC, 1'b1, 2'b10, 32'h0);
        rd(4'h4, 1'b0, 2'b10, 32'h0);
        rd(4'h4, 1'b1, 2'b00, 32'h0);
        wbuf[0] = 8'h77;
        s0 = starts.size();
        wr_burst(4'h0, 1, 1'b0, 2'b10);
        wr_burst(4'h0, 1, 1'b1, 2'b00);
        wr_burst(4'h8, 1, 1'b1, 2'b10);
        wr_burst(4'hC, 1, 1'b1, 2'b10);
        rd(4'h4, 1'b1, 2'b10, 32'h0000_0002);
        repeat (20) @(negedge HCLK);
        chk("ignored_writes_no_frame", starts.size(), s0);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("rd_queue_drained", rd_exp.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_uart_tx.md
Name: mfp_ahb_uart_tx

Overview:
- Memory-mapped AHB-Lite slave and UART transmitter; the transmit counterpart to the serial-loader receive path (UART_RX) in the MIPS system.
- The core's AHB master writes bytes into a TX FIFO. The block serialises them 8N1 on UART_TX and exposes a status register for polling.
- Instantiated inside the AHB module, with its select decoded from the GPIO address region.

Parameters:
- BAUD_DIV, 434, HCLK cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- HCLK  in  1  bus clock; all logic is on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  4  byte address within the block; HADDR[3:2] selects the register.
- HTRANS  in  2  transfer type; a transfer is active when HTRANS[1]=1.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data; the data phase follows the address phase.
- HRDATA  out  32  read data, valid in the data phase.
- UART_TX  out  1  serial output; idles high.
- TX_IRQ  out  1  high while the FIFO is empty and the FSM is IDLE (transmit done).

Behaviour:
- Registers, selected by HADDR[3:2]:
  - 0 TXDATA: write pushes HWDATA[7:0] (little-endian, SI_Endian=0). Reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[31:8] = 0, bits[7:4] = FIFO count. Writing 1 to bit3 clears overflow; other write bits are ignored.
  - 2, 3: reads return 0; writes are ignored.
- Address phase: when HSEL & HTRANS[1], register sel_q=1, wr_q=HWRITE, a_q=HADDR[3:2]. Otherwise sel_q=0.
- Data phase:
  - Writes act on cycle N+1 using HWDATA.
  - HRDATA is a combinational mux of a_q and the current status; it reads 0 when sel_q=0.
  - Zero wait states; the block has no HREADY/HRESP outputs.
- FIFO push:
  - A write to TXDATA when not full: entry is written and count increments.
  - When full and no pop in the same cycle: byte is dropped, overflow is set, FIFO is unchanged.
  - When full with a pop in the same cycle: push is accepted and count is unchanged.
- FSM states and transitions:
  - IDLE: UART_TX=1. If the FIFO is not empty, pop into shreg and go to START; load the baud counter with BAUD_DIV-1.
  - START: UART_TX=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: UART_TX=shreg[0], LSB first; shift every BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: UART_TX=1 for BAUD_DIV cycles. If the FIFO is then not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: down-counter; a bit ends when it reaches 0, then it reloads BAUD_DIV-1. Width is 16 bits.
- Frame length: exactly 10*BAUD_DIV cycles.
- Latency: a write data phase in cycle N makes the FIFO non-empty at N+1. The FSM pops at N+1, and UART_TX falls at N+2.
- Bit index: 3-bit counter; there is no wrap beyond 7.
- Reset (asynchronous, any time, including mid-frame):
  - FSM=IDLE, UART_TX=1, FIFO count=0, pointers=0, overflow=0, sel_q=0, HRDATA=0, TX_IRQ=1.
  - A partial frame is abandoned; the line returns high immediately.
- FIFO pointers: FIFO_AW-bit, wrapping naturally. The count is FIFO_AW+1 bits so full and empty are unambiguous. STATUS[7:4] saturates at 15 when count=16; full (bit0) distinguishes that case.

Decomposition:
- Shared package/header mfp_ahb_const.vh gains:
  - MFP_UART_TX_DATA_OFS = 0 and MFP_UART_TX_STAT_OFS = 4.
  - The status bit-position constants.
  - The FSM state encodings IDLE=0, START=1, DATA=2, STOP=3.
- Sub-module mfp_sync_fifo (parameters: width 8, FIFO_AW):
  - Ports: push, pop, din, dout, full, empty, count.
  - dout is valid when not empty (first-word fall-through).
- The top of this block holds the AHB slave logic, the baud counter and the FSM.

Test Plan (BAUD_DIV=4, FIFO_AW=2):
- Reset release, then read STATUS -> HRDATA = 0x00000002; UART_TX = 1; TX_IRQ = 1.
- Write 0xA5 to TXDATA in cycle N -> UART_TX falls at N+2. Sampled every 4 cycles it gives 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop). STATUS bit2 = 1 during the frame; TX_IRQ returns to 1 at N+42.
- Write 0x01, 0x02, 0x03 back-to-back -> three contiguous frames of 40 cycles each, with no high gap between a stop bit and the next start bit.
- Write 6 bytes with no pop opportunity -> 5 accepted (4 in the FIFO plus 1 popped). Overflow sets, STATUS bit3 = 1 and bit0 = 1. Writing 0x8 to STATUS clears bit3.
- Assert HRESETn low mid-DATA bit 3 -> UART_TX = 1 asynchronously; after release, STATUS = 0x00000002 and no residual frame is sent.
- Read TXDATA and offset 0xC, and access with HSEL=0 or HTRANS=IDLE -> HRDATA = 0 and no FIFO change.
